// File: rtl/fir_filter_mac.sv
// Time-multiplexed FIR filter: one shared multiplier walks the taps one per cycle,
// then rounds and saturates the accumulated sum back to the sample width.
module fir_filter_mac #(
  parameter int DATA_W  = 16,
  parameter int COEFF_W = 16,
  parameter int TAPS    = 8,
  parameter int FRAC    = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   x_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W-1:0]   y_out,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEFF_W-1:0]  coef_data,
  output logic                       busy
);

  localparam int ADDR_W = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEFF_W;
  localparam int ACC_W  = PROD_W + ADDR_W;

  localparam logic [ADDR_W-1:0]      IDX_LAST = ADDR_W'(TAPS - 1);
  localparam logic signed [ACC_W:0]  HALF     = (ACC_W+1)'(1) << (FRAC - 1);
  localparam logic signed [ACC_W:0]  SAT_MAX  = (ACC_W+1)'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W:0]  SAT_MIN  = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state_reg, state_next;

  logic signed [DATA_W-1:0]  x_tap [TAPS];
  logic signed [COEFF_W-1:0] c_tap [TAPS];

  logic signed [ACC_W-1:0]   acc_reg;
  logic [ADDR_W-1:0]         idx_reg;
  logic signed [DATA_W-1:0]  y_reg;

  logic                      accept;
  logic                      coef_write;
  logic                      last_tap;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W:0]     rnd;
  logic signed [ACC_W:0]     shifted;
  logic signed [DATA_W-1:0]  y_sat;

  assign accept     = in_valid && (state_reg == IDLE);
  assign coef_write = coef_we && (state_reg == IDLE) && (int'(coef_addr) < TAPS);
  assign last_tap   = (idx_reg == IDX_LAST);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (accept) state_next = MAC;
      end
      MAC: begin
        if (last_tap) state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ------------------------------------------------ delay line and coefficients
  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
      logic signed [DATA_W-1:0]  x_reg;
      logic signed [COEFF_W-1:0] c_reg;

      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (!rst_n)      x_reg <= '0;
          else if (accept) x_reg <= x_in;
        end
      end else begin : g_shift
        always_ff @(posedge clk) begin
          if (!rst_n)      x_reg <= '0;
          else if (accept) x_reg <= x_tap[gi-1];
        end
      end

      // A write landing on the acceptance cycle is visible to the first MAC cycle.
      always_ff @(posedge clk) begin
        if (!rst_n)
          c_reg <= '0;
        else if (coef_write && (coef_addr == ADDR_W'(gi)))
          c_reg <= coef_data;
      end

      assign x_tap[gi] = x_reg;
      assign c_tap[gi] = c_reg;
    end
  endgenerate

  // ------------------------------------------------------------- datapath
  assign prod    = x_tap[idx_reg] * c_tap[idx_reg];
  assign acc_sum = acc_reg + ACC_W'(prod);
  assign rnd     = (ACC_W+1)'(acc_sum) + HALF;
  assign shifted = rnd >>> FRAC;

  always_comb begin
    y_sat = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX)      y_sat = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) y_sat = SAT_MIN[DATA_W-1:0];
  end

  // The final product is folded in on the MAC->OUT edge, so MAC lasts exactly TAPS cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg <= '0;
      idx_reg <= '0;
      y_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            acc_reg <= '0;
            idx_reg <= '0;
          end
        end
        MAC: begin
          acc_reg <= acc_sum;
          if (last_tap) y_reg   <= y_sat;
          else          idx_reg <= idx_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign y_out = y_reg;

endmodule
